// File: rtl/strobe_sched_if.sv
// Output port of strobe_sched: valid/ready handshake carrying requester id and sample.
// With STROBE_SCHED_TIMESTAMP_EN defined the port also carries the capture timestamp.
interface strobe_sched_if #(
    parameter int DW  = 32,
    parameter int IDW = 2
);
    logic           out_valid;
    logic           out_ready;
    logic [IDW-1:0] out_id;
    logic [DW-1:0]  out_data;
`ifdef STROBE_SCHED_TIMESTAMP_EN
    logic [15:0]    out_time;

    modport master (output out_valid, output out_id, output out_data, output out_time,
                    input  out_ready);
    modport slave  (input  out_valid, input  out_id, input  out_data, input  out_time,
                    output out_ready);
`else
    modport master (output out_valid, output out_id, output out_data,
                    input  out_ready);
    modport slave  (input  out_valid, input  out_id, input  out_data,
                    output out_ready);
`endif
endinterface

// File: rtl/strobe_sched.sv
// Strobe scheduler: per-requester post-update samples of one variable, drained round-robin.
// Optional capture timestamps are enabled with STROBE_SCHED_TIMESTAMP_EN.
module strobe_sched #(
    parameter int NREQ = 4,
    parameter int DW   = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic [DW-1:0]   wr_data,
    input  logic [NREQ-1:0] req,
    output logic [DW-1:0]   cur_value,
    output logic [NREQ-1:0] pending,
    output logic [NREQ-1:0] overflow,
    strobe_sched_if.master  dout
);
    localparam int IDW = $clog2(NREQ);

    logic [DW-1:0]   cur_reg;
    logic [DW-1:0]   sample;
    logic [NREQ-1:0] pend_reg, pend_next;
    logic [NREQ-1:0] ovf_reg, ovf_next;
    logic [NREQ-1:0] is_grant;
    logic [DW-1:0]   slot_data_reg [NREQ];
    logic [IDW-1:0]  rr_reg, rr_next;
    logic [IDW-1:0]  grant;
    logic            grant_vld;
    logic            load;
    logic            fire;
    logic            ovalid_reg;
    logic [IDW-1:0]  oid_reg;
    logic [DW-1:0]   odata_reg;

    function automatic logic [IDW-1:0] rr_add(input logic [IDW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NREQ) s = s - NREQ;
        return IDW'(s);
    endfunction

    // Same-cycle write is visible to the sample: last update in the cycle wins.
    assign sample = wr_en ? wr_data : cur_reg;
    assign load   = !ovalid_reg || dout.out_ready;
    assign fire   = load && grant_vld;

    always_comb begin
        logic [IDW-1:0] idx;
        grant     = '0;
        grant_vld = 1'b0;
        idx       = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = rr_add(rr_reg, k);
            if (!grant_vld && pend_reg[idx]) begin
                grant_vld = 1'b1;
                grant     = idx;
            end
        end
    end

    assign rr_next = rr_add(grant, 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_reg <= '0;
        end else if (wr_en) begin
            cur_reg <= wr_data;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_slot
            assign is_grant[gi]  = fire && (grant == IDW'(gi));
            // A re-request on the grant cycle refills the slot without losing anything.
            assign pend_next[gi] = req[gi] | (pend_reg[gi] & ~is_grant[gi]);
            assign ovf_next[gi]  = ovf_reg[gi] | (req[gi] & pend_reg[gi] & ~is_grant[gi]);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    slot_data_reg[gi] <= '0;
                end else if (req[gi]) begin
                    slot_data_reg[gi] <= sample;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_reg <= '0;
            ovf_reg  <= '0;
        end else begin
            pend_reg <= pend_next;
            ovf_reg  <= ovf_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovalid_reg <= 1'b0;
            oid_reg    <= '0;
            odata_reg  <= '0;
            rr_reg     <= '0;
        end else if (fire) begin
            ovalid_reg <= 1'b1;
            oid_reg    <= grant;
            odata_reg  <= slot_data_reg[grant];
            rr_reg     <= rr_next;
        end else if (ovalid_reg && dout.out_ready) begin
            ovalid_reg <= 1'b0;
        end
    end

`ifdef STROBE_SCHED_TIMESTAMP_EN
    logic [15:0] time_reg;
    logic [15:0] slot_time_reg [NREQ];
    logic [15:0] otime_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            time_reg <= '0;
        end else begin
            time_reg <= time_reg + 16'd1;
        end
    end

    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_stamp
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    slot_time_reg[gi] <= '0;
                end else if (req[gi]) begin
                    slot_time_reg[gi] <= time_reg;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            otime_reg <= '0;
        end else if (fire) begin
            otime_reg <= slot_time_reg[grant];
        end
    end

    assign dout.out_time = otime_reg;
`endif

    assign cur_value     = cur_reg;
    assign pending       = pend_reg;
    assign overflow      = ovf_reg;
    assign dout.out_valid = ovalid_reg;
    assign dout.out_id    = oid_reg;
    assign dout.out_data  = odata_reg;
endmodule

// File: tb/tb_strobe_sched.sv
// Directed bench for strobe_sched: same-cycle write, chaining, fairness, overwrite, collision, reset.
module tb_strobe_sched;
    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int IDW  = 2;

    logic            clk;
    logic            rst_n;
    logic            wr_en;
    logic [DW-1:0]   wr_data;
    logic [NREQ-1:0] req;
    logic [DW-1:0]   cur_value;
    logic [NREQ-1:0] pending;
    logic [NREQ-1:0] overflow;

    int vec_cnt;
    int err_cnt;

    strobe_sched_if #(.DW(DW), .IDW(IDW)) oif ();

    strobe_sched #(.NREQ(NREQ), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .req       (req),
        .cur_value (cur_value),
        .pending   (pending),
        .overflow  (overflow),
        .dout      (oif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s got=%h", tag, got);
        end
    endtask

    // Advance one edge; outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [31:0] wd, input logic [3:0] rq);
        wr_en   = we;
        wr_data = wd;
        req     = rq;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [1:0] id, input logic [31:0] d);
        chk({tag, ".valid"}, 32'(oif.out_valid), 32'(v));
        chk({tag, ".id"},    32'(oif.out_id),    32'(id));
        chk({tag, ".data"},  oif.out_data,       d);
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        rst_n = 1'b0;
        oif.out_ready = 1'b1;
        drive(1'b0, 32'h0, 4'b0000);
        tick();
        tick();
        chk("rst.cur", cur_value, 32'h0);
        chk_out("rst", 1'b0, 2'd0, 32'h0);
        chk("rst.pend", 32'(pending), 32'h0);
        chk("rst.ovf", 32'(overflow), 32'h0);
`ifdef STROBE_SCHED_TIMESTAMP_EN
        chk("rst.time", 32'(oif.out_time), 32'h0);
`endif
        rst_n = 1'b1;

        // Same-cycle write must be seen by the sample.
        drive(1'b1, 32'h1, 4'b0001);
        tick();
        chk("sc.cur", cur_value, 32'h1);
        chk("sc.pend", 32'(pending), 32'h1);
        chk("sc.early", 32'(oif.out_valid), 32'h0);
        drive(1'b0, 32'h0, 4'b0000);
        tick();
        chk_out("sc", 1'b1, 2'd0, 32'h1);
        tick();
        chk("sc.drain", 32'(oif.out_valid), 32'h0);

        // Chained requests on slot 0 with writes 1,2,3.
        drive(1'b1, 32'h1, 4'b0001);
        tick();
        drive(1'b1, 32'h2, 4'b0001);
        tick();
        chk_out("ch1", 1'b1, 2'd0, 32'h1);
        drive(1'b1, 32'h3, 4'b0001);
        tick();
        chk_out("ch2", 1'b1, 2'd0, 32'h2);
        drive(1'b0, 32'h0, 4'b0000);
        tick();
        chk_out("ch3", 1'b1, 2'd0, 32'h3);
        chk("ch.ovf", 32'(overflow), 32'h0);
        chk("ch.pend", 32'(pending), 32'h0);
        tick();

        // Grant slot 1 so rr lands on 2, with cur_value 0x55.
        drive(1'b1, 32'h55, 4'b0010);
        tick();
        drive(1'b0, 32'h0, 4'b0000);
        tick();
        chk_out("rr2", 1'b1, 2'd1, 32'h55);
        tick();
        chk("rr2.drain", 32'(oif.out_valid), 32'h0);

        // All-request fairness from rr=2.
        drive(1'b0, 32'h0, 4'b1111);
        tick();
        chk("all.pend", 32'(pending), 32'hF);
        drive(1'b0, 32'h0, 4'b0000);
        tick();
        chk_out("all0", 1'b1, 2'd2, 32'h55);
        tick();
        chk_out("all1", 1'b1, 2'd3, 32'h55);
        tick();
        chk_out("all2", 1'b1, 2'd0, 32'h55);
        tick();
        chk_out("all3", 1'b1, 2'd1, 32'h55);
        chk("all.pend0", 32'(pending), 32'h0);
        tick();

        // Backpressure: occupy output with slot 2, then overwrite slot 1.
        oif.out_ready = 1'b0;
        drive(1'b1, 32'h77, 4'b0100);
        tick();
        drive(1'b0, 32'h0, 4'b0000);
        tick();
        chk_out("bp.fill", 1'b1, 2'd2, 32'h77);
        drive(1'b1, 32'hA, 4'b0010);
        tick();
        chk("bp.ovf0", 32'(overflow), 32'h0);
        drive(1'b1, 32'hB, 4'b0010);
        tick();
        chk("bp.ovf1", 32'(overflow), 32'h2);
        chk_out("bp.hold", 1'b1, 2'd2, 32'h77);
        drive(1'b0, 32'h0, 4'b0000);
        oif.out_ready = 1'b1;
        tick();
        chk_out("bp.emit", 1'b1, 2'd1, 32'hB);
        tick();
        chk("bp.single", 32'(oif.out_valid), 32'h0);

        // Grant/re-request collision on slot 3.
        drive(1'b1, 32'h7, 4'b1000);
        tick();
        drive(1'b1, 32'h9, 4'b1000);
        tick();
        chk_out("col1", 1'b1, 2'd3, 32'h7);
        chk("col.pend", 32'(pending), 32'h8);
        drive(1'b0, 32'h0, 4'b0000);
        tick();
        chk_out("col2", 1'b1, 2'd3, 32'h9);
        chk("col.ovf", 32'(overflow), 32'h2);
        tick();

        // Reset while entries are pending and one sits on the output.
        oif.out_ready = 1'b0;
        drive(1'b1, 32'h5, 4'b0111);
        tick();
        drive(1'b0, 32'h0, 4'b0000);
        tick();
        chk_out("mr.pre", 1'b1, 2'd0, 32'h5);
        chk("mr.prepend", 32'(pending), 32'h6);
        rst_n = 1'b0;
        #1;
        chk_out("mr.rst", 1'b0, 2'd0, 32'h0);
        chk("mr.pend", 32'(pending), 32'h0);
        chk("mr.ovf", 32'(overflow), 32'h0);
        chk("mr.cur", cur_value, 32'h0);
`ifdef STROBE_SCHED_TIMESTAMP_EN
        chk("mr.time", 32'(oif.out_time), 32'h0);
`endif
        tick();
        rst_n = 1'b1;
        oif.out_ready = 1'b1;
        tick();
        chk("mr.idle1", 32'(oif.out_valid), 32'h0);
        drive(1'b0, 32'h0, 4'b0001);
        tick();
        chk("mr.idle2", 32'(oif.out_valid), 32'h0);
        drive(1'b0, 32'h0, 4'b0000);
        tick();
        chk_out("mr.new", 1'b1, 2'd0, 32'h0);
`ifdef STROBE_SCHED_TIMESTAMP_EN
        chk("mr.newtime", 32'(oif.out_time), 32'h1);
`endif
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/strobe_sched.md
Name: strobe_sched

Overview:
- Hardware model of deferred-display (strobe) scheduling for the dynamic-scheduling regression area.
- NREQ requesters each ask for a post-update sample of one shared monitored variable. A request made in a cycle captures the variable's value as it stands at the end of that cycle, including any write in the same cycle.
- Captured samples are held in per-requester slots. A round-robin arbiter drains them one at a time through a valid/ready output port to the bench's print/check logic.

Parameters:
- NREQ, 4, number of requesters (2..16)
- DW, 32, width of monitored variable and samples
- IDW, $clog2(NREQ), width of requester id (derived, not overridable)

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- wr_en  input  1  update monitored variable this cycle
- wr_data  input  DW  new value of monitored variable
- req  input  NREQ  per-requester strobe request, one-cycle pulses
- cur_value  output  DW  current registered monitored variable
- out_valid  output  1  output entry available
- out_ready  input  1  consumer accepts entry
- out_id  output  IDW  requester that issued the entry
- out_data  output  DW  sampled value
- pending  output  NREQ  slot-occupied flags
- overflow  output  NREQ  sticky per-requester overwrite flags

Behaviour:
- Reset (async assert, sync release): cur_value=0, pending=0, overflow=0, out_valid=0, out_id=0, out_data=0, rr pointer=0.
- Monitored variable: cur_value <= wr_data when wr_en, else holds.
- Sample value: S = wr_en ? wr_data : cur_value. This is strobe semantics, last update in the cycle wins.
- Capture: req[i] at edge E loads slot i with S and sets pending[i].
- Output register: loadable when !out_valid or (out_valid && out_ready).
- Arbitration when loadable and any pending:
  - Grant the first pending index at or after rr pointer, wrapping modulo NREQ.
  - Load out_id/out_data from that slot and set out_valid.
  - Clear pending[grant], unless req[grant] is also asserted in the same cycle.
  - rr pointer <= grant+1 (wraps to 0 after NREQ-1).
- Drain: if out_valid && out_ready and nothing is pending, out_valid <= 0.
- Stability: out_id/out_data hold while out_valid && !out_ready.
- Latency: req at edge E0 -> out_valid high after E1 at the earliest, with out_ready=1 and no competitors.
- Throughput: one entry per cycle while out_ready=1.
- Request on a pending slot:
  - req[i] while pending[i] and slot i not granted that cycle: slot data is replaced with the new S and overflow[i] sets. The old sample is lost.
  - req[i] in the same cycle slot i is granted: the old sample moves to the output, the new S loads the slot, pending stays 1, no overflow.
- Simultaneous requests from all NREQ requesters: all captured with identical S, then emitted in rr order over NREQ cycles.
- overflow clears only on reset.
- Reset mid-operation: pending slots and any unconsumed output entry are discarded.

Optional Feature:
- Macro: STROBE_SCHED_TIMESTAMP_EN
- Defined:
  - Adds a free-running 16-bit cycle counter, 0 at reset, wraps 0xFFFF->0.
  - Adds output port out_time[15:0]: counter value at the capture edge of the emitted entry, stored per slot, overwritten together with slot data.
  - out_time resets to 0.
- Undefined: no counter, no per-slot timestamp storage, no out_time port.

Test Plan:
- Same-cycle write: cur_value=0; in one cycle wr_en=1, wr_data=1, req=0001. Required: out_valid one cycle later with out_id=0, out_data=1 (not 0).
- Chained sequence: req[0] with writes 1, 2, 3 on successive request cycles, out_ready=1. Required: outputs data 1, 2, 3 in order, overflow=0.
- All-request fairness: rr=2, cur_value=0x55, req=1111, out_ready=1. Required: ids 2,3,0,1 on consecutive cycles, all data 0x55, pending=0 afterwards.
- Backpressure/overwrite: out_ready=0, req[1] with S=0xA, then req[1] with S=0xB. Required: overflow[1]=1; after out_ready=1, a single id 1 entry with data 0xB is emitted.
- Grant/re-request collision: req[3] captures 7; on its grant cycle req[3] again with wr_data=9. Required: out_data=7, then 9, overflow[3]=0.
- Reset mid-drain: two entries pending, rst_n low for one cycle. Required: all outputs 0 immediately, no entries emitted after release; with STROBE_SCHED_TIMESTAMP_EN defined, out_time=0 and the counter restarts at 0.
